// File: rtl/ifetch32.sv
// Instruction fetch front end: one request per cycle into a three-entry
// instruction buffer. Decoder redirects flush both the buffer and the tag.
module ifetch32 #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic        clk,
    input  logic        nreset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        br_take,
    input  logic [31:0] br_target,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam logic [1:0] LAST  = 2'(FIFO_DEPTH - 1);
    localparam logic [1:0] FULL  = 2'(FIFO_DEPTH);
    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    logic [31:0] fpc;
    logic [31:0] req_pc;
    logic        inflight;
    logic [31:0] buf_instr [FIFO_DEPTH];
    logic [31:0] buf_pc    [FIFO_DEPTH];
    logic [1:0]  wptr;
    logic [1:0]  rptr;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic [2:0]  occupancy;
    logic        issue;
    logic        push;
    logic        pop;
    logic        unused_target_bits;

    assign unused_target_bits = ^br_target[1:0];

    // Reserve a slot for the outstanding request so a push can never overflow.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign issue     = (occupancy < DEPTH) && !br_take;
    assign push      = inflight && !br_take;
    assign pop       = instr_valid && instr_ready;

    assign imem_addr   = {fpc[31:2], 2'b00};
    assign instr_valid = (count != 2'd0);
    assign instr_out   = buf_instr[rptr];
    assign instr_pc    = buf_pc[rptr];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            fpc      <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            count    <= 2'd0;
        end else if (br_take) begin
            fpc      <= {br_target[31:2], 2'b00};
            inflight <= 1'b0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            count    <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc    <= fpc + 32'd4;
                req_pc <= {fpc[31:2], 2'b00};
            end
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            count <= count_nxt;
        end
    end

    // Buffer storage carries no reset; it is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wptr] <= imem_data;
            buf_pc[wptr]    <= req_pc;
        end
    end

    no_overflow: assert property (
        @(posedge clk) disable iff (nreset) !(push && count == FULL)
    );

endmodule

// File: tb/tb_ifetch32.sv
// Self-checking bench for ifetch32: directed vector table, reset and
// wrap-around checks, then randomized traffic against a stream-level model.
module tb_ifetch32;

    logic        clk;
    logic        nreset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        br_take;
    logic [31:0] br_target;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [31:0] hi_addr;
    logic [31:0] hi_data;
    logic [31:0] hi_out;
    logic [31:0] hi_pc;
    logic        hi_valid;
    logic        hi_br;
    logic [31:0] hi_tgt;
    logic        hi_rdy;

    int total = 0;
    int bad   = 0;

    ifetch32 dut (
        .clk        (clk),
        .nreset     (nreset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .br_take    (br_take),
        .br_target  (br_target),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    ifetch32 #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk        (clk),
        .nreset     (nreset),
        .imem_addr  (hi_addr),
        .imem_data  (hi_data),
        .br_take    (hi_br),
        .br_target  (hi_tgt),
        .instr_out  (hi_out),
        .instr_pc   (hi_pc),
        .instr_valid(hi_valid),
        .instr_ready(hi_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 + (a >> 2);
    endfunction

    // Synchronous memory: data for an address appears the following cycle.
    always @(posedge clk) begin
        imem_data <= mem_word(imem_addr);
        hi_data   <= mem_word(hi_addr);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        v;
        logic [31:0] pc;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rdy, logic br, logic [31:0] tgt,
                                logic v, logic [31:0] pc, logic [31:0] addr);
        vec_t r;
        r.rdy = rdy; r.br = br; r.tgt = tgt;
        r.v = v; r.pc = pc; r.addr = addr;
        return r;
    endfunction

    logic [31:0] exp_pc;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        prev_valid;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_out;
    int          since_br;

    initial begin
        nreset    = 1'b1;
        br_take   = 1'b0;
        br_target = 32'h0;
        instr_ready = 1'b0;
        hi_br  = 1'b0;
        hi_tgt = 32'h0;
        hi_rdy = 1'b1;

        // Fill stall, drain, redirect with partly full buffer,
        // redirect on a transfer, then back-to-back redirects.
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 32'h8));
        for (int k = 3; k < 12; k++)
            tbl.push_back(mk(0, 0, 0, 1, 32'h0, 32'hC));
        tbl.push_back(mk(1, 0, 0, 1, 32'h0,  32'hC));
        tbl.push_back(mk(1, 0, 0, 1, 32'h4,  32'hC));
        tbl.push_back(mk(1, 0, 0, 1, 32'h8,  32'h10));
        tbl.push_back(mk(1, 0, 0, 1, 32'hC,  32'h14));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 32'h18));
        tbl.push_back(mk(0, 1, 32'h103, 1, 32'h10, 32'h1C));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h100));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h104));
        tbl.push_back(mk(1, 0, 0, 1, 32'h100, 32'h108));
        tbl.push_back(mk(1, 0, 0, 1, 32'h104, 32'h10C));
        tbl.push_back(mk(1, 1, 32'h200, 1, 32'h108, 32'h110));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h200));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h204));
        tbl.push_back(mk(1, 0, 0, 1, 32'h200, 32'h208));
        tbl.push_back(mk(1, 1, 32'h300, 1, 32'h204, 32'h20C));
        tbl.push_back(mk(1, 1, 32'h407, 0, 0, 32'h300));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h404));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h408));
        tbl.push_back(mk(1, 0, 0, 1, 32'h404, 32'h40C));

        repeat (3) step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_hi_valid", 32'(hi_valid), 32'd0);
        chk("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);

        nreset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_out", i), instr_out, mem_word(tbl[i].pc));
            end
            if (i < 2)
                chk($sformatf("hi%0d_valid", i), 32'(hi_valid), 32'd0);
            else if (i < 5) begin
                chk($sformatf("hi%0d_valid", i), 32'(hi_valid), 32'd1);
                chk($sformatf("hi%0d_pc", i), hi_pc,
                    32'hFFFF_FFF8 + 32'(4 * (i - 2)));
                chk($sformatf("hi%0d_out", i), hi_out,
                    mem_word(32'hFFFF_FFF8 + 32'(4 * (i - 2))));
            end
            instr_ready = tbl[i].rdy;
            br_take     = tbl[i].br;
            br_target   = tbl[i].tgt;
            step();
        end

        // Fill the buffer, then pulse reset between clock edges.
        instr_ready = 1'b0;
        br_take     = 1'b0;
        repeat (6) step();
        chk("full_valid", 32'(instr_valid), 32'd1);
        #2;
        nreset = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        step();
        step();
        nreset      = 1'b0;
        instr_ready = 1'b1;
        chk("rel_c0_valid", 32'(instr_valid), 32'd0);
        step();
        chk("rel_c1_valid", 32'(instr_valid), 32'd0);
        step();
        chk("rel_c2_valid", 32'(instr_valid), 32'd1);
        chk("rel_c2_pc", instr_pc, 32'h0);

        // Random traffic: delivered stream must be sequential from the
        // last redirect, with fixed redirect latency and stable holds.
        exp_pc     = 32'h0;
        since_br   = 2;
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
        prev_pc    = 32'h0;
        prev_out   = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (since_br < 100) since_br++;
            if (since_br == 1 || since_br == 2)
                chk("rnd_flush_valid", 32'(instr_valid), 32'd0);
            else if (since_br >= 3)
                chk("rnd_live_valid", 32'(instr_valid), 32'd1);
            chk("rnd_addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (prev_hold) begin
                chk("rnd_hold_valid", 32'(instr_valid), 32'd1);
                chk("rnd_hold_pc", instr_pc, prev_pc);
                chk("rnd_hold_out", instr_out, prev_out);
            end
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            if (instr_valid && rdy) begin
                chk("rnd_pc", instr_pc, exp_pc);
                chk("rnd_out", instr_out, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (br) begin
                exp_pc   = {tgt[31:2], 2'b00};
                since_br = 0;
            end
            prev_valid = instr_valid;
            prev_hold  = instr_valid && !rdy && !br;
            prev_pc    = instr_pc;
            prev_out   = instr_out;
            instr_ready = rdy;
            br_take     = br;
            br_target   = tgt;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
